// File: rtl/uart_pkg.sv
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared register map, status bit positions and receive FSM
//             states for the console UART (receive and transmit paths).
//             Optional feature macro: UART_RX_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Word offsets within the UART register window
    localparam logic [1:0] c_reg_stat = 2'd0;
    localparam logic [1:0] c_reg_rx   = 2'd1;
    localparam logic [1:0] c_reg_tx   = 2'd2;

    // UART_STAT bit positions; TX bits are ORed in by the transmit block
    localparam int c_stat_rxempty = 0;
    localparam int c_stat_rxfull  = 1;
    localparam int c_stat_txempty = 2;
    localparam int c_stat_txfull  = 3;
    localparam int c_stat_frmerr  = 4;
    localparam int c_stat_overrun = 5;
    localparam int c_stat_parerr  = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    function automatic logic f_even_parity(input logic [7:0] i_data);
        return ^i_data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_fifo.sv
// ============================================================================
//  Module   : uart_fifo
//  Purpose  : Circular FIFO with one extra pointer bit to tell full from
//             empty; a push while full succeeds when a pop happens together.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int            c_aw  = $clog2(DEPTH);
    localparam logic [c_aw:0] c_one = (c_aw + 1)'(1);

    logic [c_aw:0]      r_wr_ptr;
    logic [c_aw:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_wr_en;
    logic               w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_rd_en = i_pop & ~o_empty;
    assign w_wr_en = i_push & (~o_full | w_rd_en);
    assign o_dout  = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_one;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + c_one;
        end
    end

    // When full, the write slot is the one being read this cycle; the old
    // value is still presented on o_dout until the edge.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[c_aw-1:0]] <= i_din;
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
//  Module   : uart_rx_core
//  Purpose  : 8N1 serial receiver with FIFO and UART_STAT / UART_RX read port.
//             Define UART_RX_PARITY_EN for an even-parity bit before STOP.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_core #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic        rd_valid,
    input  logic [3:2]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rx_irq
);

    import uart_pkg::*;

    localparam int              c_cw   = $clog2(CLKS_PER_BIT);
    localparam logic [c_cw-1:0] c_half = c_cw'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cw-1:0] c_full = c_cw'(CLKS_PER_BIT - 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    logic            r_rxd_meta;
    logic            r_rxd_sync;
    rx_state_t       r_state;
    rx_state_t       w_state_nxt;
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt_nxt;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            w_tick;
    logic            w_push;
    logic            w_frm_set;
    logic            w_ovr_set;
    logic            r_frmerr;
    logic            r_overrun;
    logic            r_parerr;
    logic            w_rd_stat;
    logic            w_rd_rx;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [7:0]      w_dout;
    logic [31:0]     w_stat;
    logic [31:0]     r_rd_data;
`ifdef UART_RX_PARITY_EN
    logic            r_par_bad;
    logic            w_par_bad_nxt;
    logic            w_par_set;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_frm_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_par_set     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!r_rxd_sync) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = c_half;
`ifdef UART_RX_PARITY_EN
                    w_par_bad_nxt = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - c_one;
                end else if (!r_rxd_sync) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = c_full;
                    w_bit_nxt   = 3'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - c_one;
                end else begin
                    w_shift_nxt = {r_rxd_sync, r_shift[7:1]};
                    w_cnt_nxt   = c_full;
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - c_one;
                end else begin
                    w_par_bad_nxt = (r_rxd_sync != f_even_parity(r_shift));
                    w_par_set     = w_par_bad_nxt;
                    w_state_nxt   = ST_STOP;
                    w_cnt_nxt     = c_full;
                end
            end
`endif
            ST_STOP: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - c_one;
                end else if (r_rxd_sync) begin
`ifdef UART_RX_PARITY_EN
                    w_push = ~r_par_bad;
`else
                    w_push = 1'b1;
`endif
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_frm_set   = 1'b1;
                    w_state_nxt = ST_BREAK;
                end
            end
            // A held-low line after a bad stop bit must not start a new frame
            ST_BREAK: begin
                if (r_rxd_sync) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_rd_stat = rd_valid && (rd_addr == c_reg_stat);
    assign w_rd_rx   = rd_valid && (rd_addr == c_reg_rx);
    assign w_pop     = w_rd_rx & ~w_empty;
    assign w_ovr_set = w_push & w_full & ~w_pop;

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (r_shift),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sticky flags: a set event in the same cycle as the clearing read wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frmerr  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_frmerr  <= w_frm_set | (r_frmerr & ~w_rd_stat);
            r_overrun <= w_ovr_set | (r_overrun & ~w_rd_stat);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_parerr <= 1'b0;
        else     r_parerr <= w_par_set | (r_parerr & ~w_rd_stat);
    end
`else
    assign r_parerr = 1'b0;
`endif

    always_comb begin
        w_stat                 = 32'd0;
        w_stat[c_stat_rxempty] = w_empty;
        w_stat[c_stat_rxfull]  = w_full;
        w_stat[c_stat_frmerr]  = r_frmerr;
        w_stat[c_stat_overrun] = r_overrun;
        w_stat[c_stat_parerr]  = r_parerr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= 32'd0;
        end else if (rd_valid) begin
            if (w_rd_stat)    r_rd_data <= w_stat;
            else if (w_rd_rx) r_rd_data <= w_empty ? 32'd0 : {24'd0, w_dout};
            else              r_rd_data <= 32'd0;
        end
    end

    assign rd_data = r_rd_data;
    assign rx_irq  = ~w_empty;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ============================================================================
//  Module   : tb_uart_rx_core
//  Purpose  : Self-checking bench for uart_rx_core: directed scenarios plus
//             random frames checked against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_core;

    localparam int CPB = 16;
    localparam int FD  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Stop bit is sampled mid-bit: half a bit plus synchronizer delay in
    localparam int STOP_CYC = (NBITS - 1) * CPB + 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic        rd_valid = 1'b0;
    logic [1:0]  rd_addr = 2'd0;
    logic [31:0] rd_data;
    logic        rx_irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] frame_rd = 32'd0;

    logic [7:0]  mq [$];
    bit          m_frm = 1'b0;
    bit          m_ovr = 1'b0;
    bit          m_par = 1'b0;

    uart_rx_core #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rd_valid (rd_valid),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rx_irq   (rx_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

    // Drives one frame bit by bit; optionally issues a read at cycle rd_cyc
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit par,
                              input int rd_cyc = -1, input logic [1:0] rd_a = 2'd0,
                              input int max_cyc = 100000, input int gap = 4);
        logic [10:0] bits;
        bits      = 11'h7FF;
        bits[0]   = 1'b0;
        bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
        bits[9]   = par;
        bits[10]  = stop;
`else
        bits[9]   = stop;
`endif
        for (int c = 0; c < NBITS * CPB && c < max_cyc; c++) begin
            @(negedge clk);
            rxd = bits[c / CPB];
            if (c == rd_cyc) begin
                rd_valid = 1'b1;
                rd_addr  = rd_a;
            end else if (c == rd_cyc + 1) begin
                rd_valid = 1'b0;
                frame_rd = rd_data;
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rxd = 1'b1;
        end
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        rd_valid = 1'b1;
        rd_addr  = a;
        @(negedge clk);
        rd_valid = 1'b0;
        d = rd_data;
    endtask

    function automatic logic [31:0] m_stat();
        return {25'd0, m_par, m_ovr, m_frm, 2'b00, (mq.size() == FD), (mq.size() == 0)};
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        if (!par_ok) m_par = 1'b1;
        if (!stop_ok)           m_frm = 1'b1;
        else if (par_ok) begin
            if (mq.size() == FD) m_ovr = 1'b1;
            else                 mq.push_back(b);
        end
    endtask

    task automatic model_rd_stat(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        exp = m_stat();
        do_read(2'd0, d);
        check(tag, d, exp);
        m_frm = 1'b0;
        m_ovr = 1'b0;
        m_par = 1'b0;
    endtask

    task automatic model_rd_rx(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        exp = (mq.size() == 0) ? 32'd0 : {24'd0, mq.pop_front()};
        do_read(2'd1, d);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        bit          s_ok;
        bit          p_ok;

        // Reset state and mid-frame reset
        repeat (3) @(negedge clk);
        check("por_rd_data", rd_data, 32'd0);
        check("por_irq", {31'd0, rx_irq}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_read(2'd0, d);
        check("por_stat", d, 32'h1);
        send_frame(8'h00, 1'b1, 1'b0, -1, 2'd0, 5 * CPB, 0);
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        check("midrst_rd_data", rd_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        do_read(2'd0, d);
        check("midrst_stat", d, 32'h1);
        check("midrst_irq", {31'd0, rx_irq}, 32'd0);
        send_frame(8'h41, 1'b1, even_par(8'h41));
        do_read(2'd1, d);
        check("after_rst_rx", d, 32'h41);

        // Single byte
        send_frame(8'hA5, 1'b1, even_par(8'hA5));
        check("single_irq", {31'd0, rx_irq}, 32'd1);
        do_read(2'd0, d);
        check("single_stat", d, 32'h0);
        do_read(2'd1, d);
        check("single_rx", d, 32'hA5);
        do_read(2'd0, d);
        check("single_stat_empty", d, 32'h1);
        repeat (5) @(negedge clk);
        check("rd_data_hold", rd_data, 32'h1);

        // Glitch, then framing error with a held break
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_irq", {31'd0, rx_irq}, 32'd0);
        do_read(2'd0, d);
        check("glitch_stat", d, 32'h1);
        send_frame(8'h3C, 1'b0, even_par(8'h3C), -1, 2'd0, 100000, 0);
        rxd = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        do_read(2'd0, d);
        check("frm_stat", d, 32'h11);
        do_read(2'd0, d);
        check("frm_stat_clr", d, 32'h01);

        // Full and overrun, then back-to-back RX reads
        for (int i = 0; i < 9; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1, even_par(b), -1, 2'd0, 100000, 0);
        end
        repeat (4) @(negedge clk);
        do_read(2'd0, d);
        check("ovr_stat", d, 32'h22);
        @(negedge clk);
        rd_valid = 1'b1;
        rd_addr  = 2'd1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 7) rd_valid = 1'b0;
            check($sformatf("b2b_rx%0d", i), rd_data, 32'(i));
        end
        do_read(2'd1, d);
        check("rx_empty_read", d, 32'h0);
        do_read(2'd0, d);
        check("ovr_stat_clr", d, 32'h01);

        // Pop coinciding with a push while full
        for (int i = 0; i < 8; i++) begin
            b = 8'h10 + 8'(i);
            send_frame(b, 1'b1, even_par(b), -1, 2'd0, 100000, (i == 7) ? 4 : 0);
        end
        do_read(2'd0, d);
        check("full_stat", d, 32'h02);
        send_frame(8'h99, 1'b1, even_par(8'h99), STOP_CYC, 2'd1);
        check("coinc_pop", frame_rd, 32'h10);
        do_read(2'd0, d);
        check("coinc_stat", d, 32'h02);
        for (int i = 1; i < 8; i++) begin
            do_read(2'd1, d);
            check($sformatf("coinc_rx%0d", i), d, 32'h10 + 32'(i));
        end
        do_read(2'd1, d);
        check("coinc_last", d, 32'h99);

        // Sticky set in the same cycle as the STAT read
        send_frame(8'h55, 1'b0, even_par(8'h55), STOP_CYC, 2'd0);
        check("sticky_coinc_rd", frame_rd, 32'h01);
        do_read(2'd0, d);
        check("sticky_kept", d, 32'h11);
        do_read(2'd0, d);
        check("sticky_clr", d, 32'h01);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        do_read(2'd1, d);
        check("par_good", d, 32'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        do_read(2'd0, d);
        check("par_bad_stat", d, 32'h41);
        check("par_bad_irq", {31'd0, rx_irq}, 32'd0);
`endif

        // Random frames against the reference model
        mq.delete();
        m_frm = 1'b0;
        m_ovr = 1'b0;
        m_par = 1'b0;
        for (int it = 0; it < 24; it++) begin
            int r;
            b    = 8'($urandom);
            s_ok = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
            p_ok = ($urandom_range(0, 7) != 0);
`else
            p_ok = 1'b1;
`endif
            send_frame(b, s_ok, even_par(b) ^ !p_ok);
            model_frame(b, s_ok, p_ok);
            check($sformatf("rnd_irq%0d", it), {31'd0, rx_irq}, {31'd0, mq.size() != 0});
            r = $urandom_range(0, 3);
            if (r == 0)      model_rd_rx($sformatf("rnd_rx%0d", it));
            else if (r == 1) model_rd_stat($sformatf("rnd_stat%0d", it));
        end
        model_rd_stat("rnd_final_stat");
        while (mq.size() != 0) model_rd_rx("rnd_drain");
        model_rd_rx("rnd_drain_empty");
        model_rd_stat("rnd_end_stat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_core.md
# uart_rx_core

Synthesizable receive half of the console UART mapped at 0x30010000. It deserializes the asynchronous serial input `rxd` (8N1, LSB first) into a small FIFO. It exposes the UART_STAT (offset 0x0) and UART_RX (offset 0x4) registers to the memory system through a single-cycle read port. It is the counterpart of the transmit path, which handles UART_TX writes; the TX block ORs its own status bits into UART_STAT.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per serial bit (100 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, 8: receive FIFO entries. Must be a power of 2 and ≥ 2.
- `clk`  in  1  core clock, the only clock.
- `rst`  in  1  asynchronous reset, active-high.
- `rxd`  in  1  serial input, idle high, asynchronous to `clk`.
- `rd_valid`  in  1  register read strobe, single cycle.
- `rd_addr`  in  [3:2]  word offset: 0 = STAT, 1 = RX, others read 0.
- `rd_data`  out  32  read data, valid the cycle after `rd_valid`.
- `rx_irq`  out  1  high while the FIFO is non-empty.

## Operation
- **Input synchronizer:** `rxd` passes through a 2-flop synchronizer (reset to 1) before any use.
- **Bit FSM states:**
  - IDLE: a sampled 0 moves to START and loads the bit counter with `CLKS_PER_BIT/2 - 1`.
  - START: at count 0, resample. If 0, go to DATA and reload `CLKS_PER_BIT-1`. If 1, treat as a glitch and return to IDLE.
  - DATA: at each count 0, shift the sample into bit [7] of the shift register, shifting right. After 8 bits, go to PARITY (when enabled) or STOP.
  - PARITY: sample the parity bit (see Configuration).
  - STOP: at count 0, sample. A 1 attempts a FIFO push. A 0 sets FRMERR, discards the byte, and moves to IDLE only once the line is seen high (break does not retrigger).
- **FIFO:** circular, with read/write pointers `$clog2(FIFO_DEPTH)+1` bits wide so full and empty are distinguishable.
  - Push when full: byte dropped, OVERRUN set.
  - Pop and push in the same cycle: both occur, including when full, and the count is unchanged.
- **UART_STAT read:**
  - bit0 RXEMPTY, bit1 RXFULL, bit4 FRMERR, bit5 OVERRUN, bit6 PARERR; all other bits 0.
  - The read clears the sticky bits 4–6. A sticky event in the same cycle as the read wins and stays set.
- **UART_RX read:** returns {24'b0, byte}. Pops the FIFO if non-empty; if empty, returns 0 with no pop.

## Timing
- **Reset values:** `rd_data` = 0, `rx_irq` = 0, FSM in IDLE, FIFO empty, sticky bits 0, synchronizer at 1.
- **Reset mid-frame:** the partial byte is lost and nothing is pushed.
- **Read latency:** 1 cycle. `rd_data` is registered and holds its value until the next `rd_valid`.
  - The pop takes effect at the same edge that registers the data.
  - Back-to-back RX reads on consecutive cycles return consecutive entries.
- **Sample point:** mid-bit, (`CLKS_PER_BIT/2` + n·`CLKS_PER_BIT`) cycles after the synchronized falling edge, plus 2 cycles of synchronizer delay.
- **Push:** happens in the cycle the stop bit is sampled. `rx_irq` and RXEMPTY update the next cycle.
- **Next frame:** a new start bit is accepted the cycle after STOP completes, so the block tolerates back-to-back frames with a 1-bit stop.

## Configuration
- **`UART_RX_PARITY_EN` defined:** an even-parity bit is expected between DATA and STOP. On mismatch, PARERR is set and the byte is discarded at STOP.
- **`UART_RX_PARITY_EN` undefined:** the PARITY state does not exist, the frame is 8N1, and STAT bit6 reads 0.

## Structure
- Package `uart_pkg` holds:
  - register offsets (STAT = 0, RX = 1, TX = 2);
  - status bit positions (RXEMPTY = 0, RXFULL = 1, TXEMPTY = 2, TXFULL = 3, FRMERR = 4, OVERRUN = 5, PARERR = 6);
  - the FSM state enum.
  The transmit block shares this package.
- Sub-module `uart_fifo`: parameterized by width and depth, with push/pop/full/empty/dout. The TX block reuses it.

## Test plan
Run all scenarios with `CLKS_PER_BIT`=16.
1. **Reset:** assert `rst` mid-frame → STAT reads 0x1, `rx_irq`=0, and the following frame 0x41 is received correctly.
2. **Single byte:** drive 0xA5 → `rx_irq` rises after about 10 bit times. STAT reads 0x0, RX reads 0x000000A5, then STAT reads 0x1.
3. **Glitch and framing:**
   - A 4-cycle low pulse on `rxd` → nothing is pushed.
   - 0x3C with stop bit 0 → STAT reads 0x11. A second STAT read returns 0x01.
4. **Full/overrun:** send 9 bytes 0x00..0x08 without reading → STAT reads 0x22. Eight RX reads return 0x00..0x07, then an RX read returns 0.
5. **Simultaneous events:**
   - FIFO full, and an RX read coincides with a stop-bit push of 0x99 → count stays 8, no OVERRUN, and 0x99 is last out.
   - A sticky set coinciding with a STAT read → the bit remains set.
6. **Parity (`UART_RX_PARITY_EN`):**
   - 0x07 with parity 1 → accepted.
   - 0x07 with parity 0 → discarded, STAT reads 0x41.
